// File: rtl/accum_frame_arbiter.sv
// Round-robin arbiter: N_SRC sources stream NO_OF_STEPS-beat frames into one accumulator; results tagged with source ID.
// Grant one cycle after request; beats and results pass through combinationally; backpressure from a_ready/m_ready.
module accum_frame_arbiter #(
  parameter int WIDTH       = 3,
  parameter int N_SRC       = 4,
  parameter int NO_OF_STEPS = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_SRC-1:0]          s_valid,
  output logic [N_SRC-1:0]          s_ready,
  input  logic [N_SRC*WIDTH-1:0]    s_data,
  output logic                      a_valid,
  input  logic                      a_ready,
  output logic [WIDTH-1:0]          a_data,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [13:0]               r_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [13:0]               m_data,
  output logic [$clog2(N_SRC)-1:0]  m_id,
  output logic                      busy,
  output logic                      err_orphan
);

  localparam int ID_W  = $clog2(N_SRC);
  localparam int CNT_W = (NO_OF_STEPS > 1) ? $clog2(NO_OF_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NO_OF_STEPS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ID_W-1:0]   fifo_q [2];
  logic [ID_W-1:0]   fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              err_orphan_q, err_orphan_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W:0]     rr_idx;
  logic              hs, pop, push, full, grant_fire;

  // First valid source at or after rr_ptr, wrapping past N_SRC-1.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    rr_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (rr_idx >= (ID_W+1)'(N_SRC)) rr_idx = rr_idx - (ID_W+1)'(N_SRC);
      if (!pick_vld && s_valid[rr_idx[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = rr_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    s_ready = '0;
    a_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == ID_W'(i)) begin
        a_data     = s_data[i*WIDTH +: WIDTH];
        s_ready[i] = (state_q == STREAM) & a_ready;
      end
    end
  end

  assign a_valid    = (state_q == STREAM) & s_valid[grant_q];
  assign busy       = (state_q == STREAM);
  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign r_ready    = m_ready;
  assign m_id       = (occ_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
  assign err_orphan = err_orphan_q;

  assign hs   = a_valid & a_ready;
  assign pop  = r_valid & m_ready & (occ_q != 2'd0);
  assign full = (occ_q == 2'd2);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a grant.
  assign grant_fire = (state_q == IDLE) & pick_vld & (~full | pop);
  assign push = grant_fire;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q ^ pop;
    wr_ptr_d     = wr_ptr_q ^ push;
    occ_d        = occ_q;
    err_orphan_d = err_orphan_q | (r_valid & m_ready & (occ_q == 2'd0));

    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          grant_d = pick_id;
          count_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          if (count_q == LAST) begin
            count_d  = '0;
            rr_ptr_d = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
            state_d  = IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) fifo_d[wr_ptr_q] = pick_id;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      count_q      <= '0;
      fifo_q       <= '{default: '0};
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_accum_frame_arbiter.sv
// Directed bench for accum_frame_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_accum_frame_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  s_valid = '0;
  logic [3:0]  s_ready;
  logic [11:0] s_data = {3'd1, 3'd6, 3'd3, 3'd5};
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [2:0]  a_data;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [13:0] r_data = 14'h1abc;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [13:0] m_data;
  logic [1:0]  m_id;
  logic        busy;
  logic        err_orphan;

  int nvec = 0;
  int nmis = 0;
  logic [2:0] sd [4] = '{3'd5, 3'd3, 3'd6, 3'd1};

  always #5 clk = ~clk;

  accum_frame_arbiter dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .busy(busy), .err_orphan(err_orphan)
  );

  typedef struct {
    logic       rn;
    logic [3:0] sv;
    logic       ar, rv, mr;
    logic [3:0] esr;
    logic       eav;
    logic [2:0] ead;
    logic       eb;
    logic [1:0] emid;
    logic       emv, err, eorph;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rn, logic [3:0] sv, logic ar, logic rv, logic mr,
                              logic [3:0] esr, logic eav, logic [2:0] ead, logic eb,
                              logic [1:0] emid, logic emv, logic err, logic eorph);
    vec_t v;
    v.rn = rn; v.sv = sv; v.ar = ar; v.rv = rv; v.mr = mr;
    v.esr = esr; v.eav = eav; v.ead = ead; v.eb = eb;
    v.emid = emid; v.emv = emv; v.err = err; v.eorph = eorph;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    cyc();
    rstn = 1'b0; s_valid = '0; a_ready = 1'b0; r_valid = 1'b0; m_ready = 1'b0;
    smp();
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order[4] = '{0, 1, 3, 0};
    logic [3:0] oh;

    // Reset, single-source frame from source 2, pop of its ID.
    tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 4'b0100, 1, 3'd6, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0, 2, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0));
    // rr_ptr now 3: source 3 frame with a_ready toggling and a one-cycle valid drop.
    tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 4'b1000, ~i[0], 0, 0, i[0] ? 4'b0000 : 4'b1000, 1, 3'd1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b1000, 0, 0, 1, 3, 0, 0, 0));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk(1, 4'b1000, ~i[0], 0, 0, i[0] ? 4'b0000 : 4'b1000, 1, 3'd1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 3, 0, 0, 0));

    foreach (tbl[n]) begin
      cyc();
      rstn = tbl[n].rn; s_valid = tbl[n].sv; a_ready = tbl[n].ar;
      r_valid = tbl[n].rv; m_ready = tbl[n].mr;
      smp();
      nvec++;
      if (s_ready !== tbl[n].esr || a_valid !== tbl[n].eav || busy !== tbl[n].eb ||
          (tbl[n].eav && a_data !== tbl[n].ead) || m_id !== tbl[n].emid ||
          m_valid !== tbl[n].emv || r_ready !== tbl[n].err || err_orphan !== tbl[n].eorph) begin
        nmis++;
        $display("FAIL vec%0d: s_ready %b/%b a_valid %b/%b a_data %0d/%0d busy %b/%b m_id %0d/%0d m_valid %b/%b r_ready %b/%b err_orphan %b/%b (got/expected)",
                 n, s_ready, tbl[n].esr, a_valid, tbl[n].eav, a_data, tbl[n].ead, busy, tbl[n].eb,
                 m_id, tbl[n].emid, m_valid, tbl[n].emv, r_ready, tbl[n].err, err_orphan, tbl[n].eorph);
      end
    end

    // Round-robin order 0,1,3,0 with one idle cycle between frames.
    do_reset();
    s_valid = 4'b1011; a_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      r_valid = (f > 0); m_ready = (f > 0);
      smp();
      chk("rr_idle_busy", 32'(busy), 0);
      chk("rr_idle_s_ready", 32'(s_ready), 0);
      if (f > 0) chk("rr_idle_m_id", 32'(m_id), 32'(order[f-1]));
      oh = 4'b0001 << order[f];
      for (int b = 0; b < 10; b++) begin
        cyc();
        r_valid = 1'b0; m_ready = 1'b0;
        smp();
        chk("rr_beat_busy", 32'(busy), 1);
        chk("rr_beat_s_ready", 32'(s_ready), 32'(oh));
        chk("rr_beat_a_data", 32'(a_data), 32'(sd[order[f]]));
      end
      cyc();
    end
    s_valid = '0;
    smp();
    chk("rr_end_busy", 32'(busy), 0);
    chk("rr_end_orphan", 32'(err_orphan), 0);

    // FIFO full blocks grant; pop and grant in the same cycle.
    do_reset();
    s_valid = 4'b0011; a_ready = 1'b1;
    smp();
    for (int b = 0; b < 10; b++) begin
      cyc(); smp();
      chk("full_fa_s_ready", 32'(s_ready), 32'(4'b0001));
    end
    cyc(); smp();
    chk("full_gap_busy", 32'(busy), 0);
    for (int b = 0; b < 10; b++) begin
      cyc();
      s_valid = 4'b1010;
      smp();
      chk("full_fb_s_ready", 32'(s_ready), 32'(4'b0010));
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      r_valid = 1'b1; m_ready = 1'b0;
      smp();
      chk("full_hold_busy", 32'(busy), 0);
      chk("full_hold_s_ready", 32'(s_ready), 0);
      chk("full_hold_m_valid", 32'(m_valid), 1);
      chk("full_hold_r_ready", 32'(r_ready), 0);
      chk("full_hold_m_id", 32'(m_id), 0);
    end
    cyc();
    m_ready = 1'b1;
    smp();
    chk("full_pop_m_id", 32'(m_id), 0);
    chk("full_pop_r_ready", 32'(r_ready), 1);
    cyc();
    m_ready = 1'b0;
    smp();
    chk("full_grant_busy", 32'(busy), 1);
    chk("full_grant_s_ready", 32'(s_ready), 32'(4'b1000));
    chk("full_grant_m_id", 32'(m_id), 1);
    cyc();
    m_ready = 1'b1;
    smp();
    chk("full_pop2_m_id", 32'(m_id), 1);
    cyc();
    r_valid = 1'b0; m_ready = 1'b0;
    smp();
    chk("full_order_m_id", 32'(m_id), 3);
    chk("full_orphan", 32'(err_orphan), 0);

    // Orphan result is sticky until reset.
    do_reset();
    r_valid = 1'b1; m_ready = 1'b1;
    smp();
    chk("orph_m_valid", 32'(m_valid), 1);
    chk("orph_m_id", 32'(m_id), 0);
    chk("orph_m_data", 32'(m_data), 32'(14'h1abc));
    chk("orph_before", 32'(err_orphan), 0);
    cyc();
    r_valid = 1'b0; m_ready = 1'b0;
    smp();
    chk("orph_set", 32'(err_orphan), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk("orph_sticky", 32'(err_orphan), 1);
    end
    cyc();
    rstn = 1'b0;
    smp();
    chk("orph_reset", 32'(err_orphan), 0);
    cyc();
    rstn = 1'b1;
    smp();
    chk("orph_after_reset", 32'(err_orphan), 0);

    // Reset at beat 5 of a source-1 frame; restart from source 0 with a full frame.
    do_reset();
    s_valid = 4'b0010; a_ready = 1'b1;
    smp();
    for (int b = 0; b < 4; b++) begin
      cyc(); smp();
      chk("mid_beat_s_ready", 32'(s_ready), 32'(4'b0010));
    end
    cyc();
    rstn = 1'b0;
    smp();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 0);
    chk("mid_rst_a_valid", 32'(a_valid), 0);
    cyc();
    rstn = 1'b1; s_valid = 4'b0011;
    smp();
    chk("mid_rel_busy", 32'(busy), 0);
    for (int b = 0; b < 10; b++) begin
      cyc(); smp();
      chk("mid_new_busy", 32'(busy), 1);
      chk("mid_new_s_ready", 32'(s_ready), 32'(4'b0001));
    end
    cyc();
    s_valid = '0;
    smp();
    chk("mid_new_end", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
